// File: rtl/fifo_push_dma_pkg.sv
// Shared constants and types for the FIFO push-side DMA initiator.
package fifo_package;

    // Word width carried from the sram to the FIFO push port.
    localparam int DATA_WIDTH = 16;

    // sram address width; burst addresses wrap modulo 2^ADDR_WIDTH.
    localparam int ADDR_WIDTH = 4;

    // Burst length needs one extra bit so a full sweep of the sram fits.
    localparam int LEN_WIDTH = ADDR_WIDTH + 1;

    // Depth of the skid buffer between the sram read port and the push port.
    localparam int BUF_DEPTH = 2;

    // Width of the buffer occupancy count (0..BUF_DEPTH).
    localparam int OCC_WIDTH = 2;

    // Burst controller states.
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } dma_state_t;

endpackage

// File: rtl/fifo_push_dma_skid_buf.sv
// Two-entry register FIFO absorbing the sram read latency under push backpressure.
// The head entry is itself a register, so rdata comes straight from a flop.
module dma_skid_buf
    import fifo_package::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata,
    output logic [OCC_WIDTH-1:0] occ
);

    logic [WIDTH-1:0]     head;
    logic [WIDTH-1:0]     tail;
    logic [OCC_WIDTH-1:0] count;

    // Shift-style storage: head always holds the oldest word; a read promotes tail.
    // A read on an empty buffer is treated as no read, and a write into a full
    // buffer without a read cannot happen because the issue logic holds credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    if (count == 2'd0) begin
                        head  <= wdata;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail  <= wdata;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head  <= tail;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        count <= 2'd0;
                    end
                end
                2'b11: begin
                    if (count == 2'd0) begin
                        head  <= wdata;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        head  <= wdata;
                    end else begin
                        head  <= tail;
                        tail  <= wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata = head;
    assign occ   = count;

endmodule

// File: rtl/fifo_push_dma.sv
// Producer-side burst initiator: reads a run of sram words starting at a base
// address and pushes them into a FIFO, honouring the push grant handshake.
module fifo_push_dma
    import fifo_package::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_re_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] push_data_o,
    output logic                  push_valid_o,
    input  logic                  push_grant_i
);

    dma_state_t            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  pushed;
    logic [LEN_WIDTH-1:0]  last_idx;
    logic                  inflight;
    logic [OCC_WIDTH-1:0]  occ;
    logic [2:0]            pending;
    logic                  pop;
    logic                  issue;

    dma_skid_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (inflight),
        .wdata (mem_rdata_i),
        .rd_en (pop),
        .rdata (push_data_o),
        .occ   (occ)
    );

    // Credit and handshake terms: a word in flight from the sram already owns a
    // buffer slot, so reads are throttled on occupancy plus in-flight reads; a pop
    // in the same cycle frees a slot, which is what sustains one word per cycle.
    always_comb begin
        pop          = 1'b0;
        issue        = 1'b0;
        pending      = 3'(occ) + 3'(inflight);
        last_idx     = len_q - LEN_WIDTH'(1);
        push_valid_o = (occ != '0);
        pop          = push_valid_o && push_grant_i;
        if (state == ACTIVE && issued < len_q) begin
            issue = (pending < 3'd2) || (pending == 3'd2 && pop);
        end
    end

    // The read address tracks base + issued, so it only moves after an issue and
    // wraps naturally at the top of the sram through truncation.
    assign mem_addr_o = base_q + issued[ADDR_WIDTH-1:0];
    assign mem_re_o   = issue;

    // Burst controller. A zero-length burst spends one quiet cycle in DONE before
    // the pulse so that its done_o lands two cycles after start; a normal burst
    // enters DONE with the pulse already raised by the final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            pushed   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued <= issued + LEN_WIDTH'(1);
            end
            if (pop) begin
                pushed <= pushed + LEN_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        base_q <= base_addr_i;
                        len_q  <= len_i;
                        issued <= '0;
                        pushed <= '0;
                        busy_o <= 1'b1;
                        state  <= (len_i == '0) ? DONE : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop && pushed == last_idx) begin
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (done_o) begin
                        done_o <= 1'b0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_dma.sv
// Self-checking bench for fifo_push_dma: drives bursts against an sram model and
// compares every read address and pushed word with a transaction-level model.
module tb_fifo_push_dma;
    import fifo_package::*;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  clk;
    logic                  rst_n;
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [LEN_WIDTH-1:0]  len_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_re_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic [DATA_WIDTH-1:0] push_data_o;
    logic                  push_valid_o;
    logic                  push_grant_i;

    logic [DATA_WIDTH-1:0] sram [0:DEPTH-1];

    int tests_run    = 0;
    int tests_failed = 0;

    fifo_push_dma dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .mem_addr_o   (mem_addr_o),
        .mem_re_o     (mem_re_o),
        .mem_rdata_i  (mem_rdata_i),
        .push_data_o  (push_data_o),
        .push_valid_o (push_valid_o),
        .push_grant_i (push_grant_i)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sram with one-cycle registered read latency.
    initial mem_rdata_i = '0;
    always @(posedge clk) begin
        if (mem_re_o) mem_rdata_i <= sram[mem_addr_o];
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one burst. grant_mode: 0 = always granted, 1 = 1,0,0 pattern, 2 = random.
    // poke_start pulses start with other arguments mid-burst; abort_mid resets
    // the design right after the second accepted word.
    task automatic applyStimulus(input int base, input int len, input int grant_mode,
                                 input bit poke_start, input bit abort_mid);
        int issued_n;
        int pushed_n;
        int done_n;
        int done_cycle;
        bit finished;
        bit prev_stall;
        logic [DATA_WIDTH-1:0] prev_data;
        issued_n   = 0;
        pushed_n   = 0;
        done_n     = 0;
        finished   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        done_cycle = (len == 0) ? 2 : 3 + len;

        @(posedge clk); #1;
        start_i      = 1'b1;
        base_addr_i  = ADDR_WIDTH'(base);
        len_i        = LEN_WIDTH'(len);
        push_grant_i = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", busy_o, 0);

        for (int k = 1; k <= 400 && !finished; k++) begin
            @(posedge clk); #1;
            start_i = poke_start && (k == 4);
            if (start_i) begin
                base_addr_i = ADDR_WIDTH'(base + 5);
                len_i       = LEN_WIDTH'(1);
            end
            case (grant_mode)
                0:       push_grant_i = 1'b1;
                1:       push_grant_i = ((k - 1) % 3 == 0);
                default: push_grant_i = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);

            if (prev_stall) begin
                checkOutput("hold_valid", push_valid_o, 1);
                checkOutput("hold_data", push_data_o, prev_data);
            end
            if (k < 3) checkOutput("early_valid", push_valid_o, 0);
            if (k == 3) checkOutput("first_valid", push_valid_o, len > 0);
            if (grant_mode == 0) checkOutput("rate_valid", push_valid_o, k >= 3 && k <= 2 + len);
            if (grant_mode == 0 || len == 0) begin
                checkOutput("done_time", done_o, k == done_cycle);
                checkOutput("busy_time", busy_o, k <= done_cycle);
            end

            if (mem_re_o) begin
                checkOutput("re_in_range", issued_n < len, 1);
                checkOutput("re_addr", mem_addr_o, (base + issued_n) % DEPTH);
                if (issued_n - pushed_n == 2)
                    checkOutput("re_credit", push_valid_o && push_grant_i, 1);
                issued_n++;
            end

            if (push_valid_o && push_grant_i) begin
                checkOutput("push_data", push_data_o, sram[(base + pushed_n) % DEPTH]);
                pushed_n++;
                if (abort_mid && pushed_n == 2) begin
                    #2;
                    rst_n   = 1'b0;
                    start_i = 1'b0;
                    #1;
                    checkOutput("abort_valid", push_valid_o, 0);
                    checkOutput("abort_busy", busy_o, 0);
                    checkOutput("abort_re", mem_re_o, 0);
                    checkOutput("abort_done", done_o, 0);
                    checkOutput("abort_data", push_data_o, 0);
                    checkOutput("abort_addr", mem_addr_o, 0);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    return;
                end
            end

            if (done_o) begin
                done_n++;
                checkOutput("done_words", pushed_n, len);
                checkOutput("done_reads", issued_n, len);
                checkOutput("done_busy", busy_o, 1);
            end else if (done_n > 0) begin
                checkOutput("post_busy", busy_o, 0);
                finished = 1'b1;
            end

            prev_stall = push_valid_o && !push_grant_i;
            prev_data  = push_data_o;
        end

        if (!finished) checkOutput("timeout", 0, 1);
        else checkOutput("one_done", done_n, 1);
        start_i = 1'b0;
    endtask

    // Test sequence: directed bursts first, then randomized bursts.
    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        base_addr_i  = '0;
        len_i        = '0;
        push_grant_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) sram[i] = DATA_WIDTH'(i + 'h100);

        #12;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_re", mem_re_o, 0);
        checkOutput("rst_valid", push_valid_o, 0);
        checkOutput("rst_addr", mem_addr_o, 0);
        checkOutput("rst_data", push_data_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus(4, 5, 0, 1'b0, 1'b0);
        applyStimulus(4, 5, 1, 1'b0, 1'b0);
        applyStimulus(14, 4, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        applyStimulus(3, DEPTH, 2, 1'b0, 1'b0);
        applyStimulus(9, 6, 0, 1'b1, 1'b0);
        applyStimulus(2, 6, 0, 1'b0, 1'b1);
        applyStimulus(0, 2, 0, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) sram[i] = DATA_WIDTH'($urandom);
            applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                          int'($urandom_range(1, 2)), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_push_dma.md
Name: fifo_push_dma

Overview:
- Producer-side initiator for the FIFO push handshake (push_data / push_valid / push_grant).
- On a start command, it reads a burst of words from an sram instance starting at a base address and pushes them into a FIFO. It obeys grant backpressure and sustains one word per cycle while grant is held high.
- Sits between the shared sram and the fifo push port. It is the writer-side counterpart of the FIFO's pop consumer.

Parameters:
- DATA_WIDTH, from fifo_package, word width.
- ADDR_WIDTH, from fifo_package, sram address width; addresses wrap modulo 2^ADDR_WIDTH.
- LEN_WIDTH, ADDR_WIDTH+1, burst length counter width; maximum length is 2^ADDR_WIDTH.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  starts a burst; sampled only in IDLE.
- base_addr_i  input  ADDR_WIDTH  first sram address; latched when start is accepted.
- len_i  input  LEN_WIDTH  number of words; latched when start is accepted.
- busy_o  output  1  high from start acceptance until done_o.
- done_o  output  1  one-cycle pulse at burst end.
- mem_addr_o  output  ADDR_WIDTH  sram read address.
- mem_re_o  output  1  read issue strobe (qualifies mem_addr_o).
- mem_rdata_i  input  DATA_WIDTH  sram read data, one-cycle registered latency.
- push_data_o  output  DATA_WIDTH  word toward the FIFO.
- push_valid_o  output  1  push request.
- push_grant_i  input  1  FIFO accepts the word when push_valid_o && push_grant_i.

Behaviour:
- Reset, asynchronous and effective immediately:
  - state = IDLE.
  - busy_o = 0, done_o = 0, mem_re_o = 0, push_valid_o = 0.
  - mem_addr_o = 0, push_data_o = 0.
  - The buffer is cleared. In-flight reads are discarded.
- States:
  - IDLE: start_i=1 latches base/len and sets busy_o=1 next cycle. If len_i==0, go to DONE; otherwise go to ACTIVE.
  - ACTIVE: issue reads and push words. When the last word handshakes, go to DONE.
  - DONE: done_o=1 and busy_o=1 for exactly one cycle, then go to IDLE with busy_o=0.
- start_i is ignored outside IDLE.
- Read issue:
  - Issue in ACTIVE while issued < len.
  - Condition: (occ + inflight < 2) || (occ + inflight == 2 && pop), where pop = push_valid_o && push_grant_i.
  - occ is the buffer occupancy (0..2). inflight is 1 when mem_re_o was asserted last cycle.
- Address generation:
  - mem_addr_o = base + issued, truncated to ADDR_WIDTH bits, so it wraps from 2^ADDR_WIDTH-1 to 0.
  - mem_addr_o holds its value when not issuing.
- Data capture: mem_rdata_i is written into the 2-entry buffer in the cycle after mem_re_o=1.
- Buffer output:
  - The buffer head drives push_data_o, registered.
  - push_valid_o = (occ != 0).
  - push_data_o and push_valid_o stay stable while push_valid_o && !push_grant_i.
- Latency:
  - start accepted at edge S.
  - First mem_re_o in cycle S+1.
  - First push_valid_o in cycle S+3.
  - With grant held at 1, one word per cycle; the last handshake is in cycle S+2+len.
  - done_o is asserted the cycle after the last handshake.
- Ordering: words are pushed in strictly increasing address order (modulo wrap). None are duplicated or dropped.
- Counter widths:
  - issued and pushed counters are LEN_WIDTH.
  - len = 2^ADDR_WIDTH reads every sram location exactly once.
- Grant held low: issue stalls once occ + inflight == 2. No word is lost.
- Reset mid-burst: outputs return to reset values immediately. No done_o pulse for the aborted burst.

Decomposition:
- Additions to fifo_package:
  - LEN_WIDTH.
  - typedef enum dma_state_t {IDLE, ACTIVE, DONE}.
  - BUF_DEPTH = 2.
- One sub-module, dma_skid_buf: 2-entry register FIFO.
  - Ports: clk, rst_n, wr_en, wdata, rd_en, rdata, occ.
  - Same-cycle write and read at occ=2 is legal.
- The top level holds the FSM, counters and the issue/credit logic.

Test Plan:
- Full-rate burst: sram[i]=i+0x100; start base=4, len=5, grant=1 always.
  - Pushes 0x104..0x108 in cycles S+3..S+7.
  - done_o in S+8.
  - busy_o high S+1..S+8.
- Backpressure: same burst, grant toggles 1,0,0,1,...
  - Same 5 words in order; each word is held stable while grant=0.
  - mem_re_o never asserted while occ+inflight==2 without a pop.
- Wrap: ADDR_WIDTH=3, base=6, len=4.
  - mem_addr_o sequence 6,7,0,1.
  - Data pushed in that address order.
- Zero and max length:
  - len=0: done_o at S+2, no push_valid_o.
  - len=8 with ADDR_WIDTH=3: all 8 words pushed once.
- Start ignored while busy: start_i pulsed during ACTIVE with a different base; burst unchanged, only one done_o.
- Reset mid-burst: rst_n low after 2 pushes.
  - push_valid_o, busy_o and mem_re_o are 0 immediately.
  - After release, a new burst base=0, len=2 completes normally.
